// File: rtl/pushbutton_conditioner.sv
// pushbutton_conditioner
//   Conditions raw, asynchronous push-button lines for the processor's
//   pushbuttons input. Each line passes through a two-flop synchronizer
//   and a per-bit debounce counter. Every debounced press is latched until
//   the processor acknowledges the read, so a short press cannot fall
//   between two IN instructions.
//
// Parameters
//   WIDTH            number of button lines (matches processor input width)
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles needed before a new
//                    synchronized level is accepted (>= 2)
//
// Ports
//   clk            processor clock
//   reset          asynchronous reset, active low
//   btn_raw        raw button lines, asynchronous, 1 = pressed
//   rd_ack         one-cycle pulse: processor has consumed btn_out
//   btn_out        btn_level | sticky, presented to the processor
//   btn_level      debounced current level of each button
//   press_pending  high while any latched press is unacknowledged
module pushbutton_conditioner #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] btn_level,
  output logic             press_pending
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("pushbutton_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [WIDTH-1:0]            s1_q, s1_d;
  logic [WIDTH-1:0]            s2_q, s2_d;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0]            sticky_q, sticky_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            rise;

  always_comb begin
    s1_d     = btn_raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        // Any cycle of agreement discards the run so far.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise = stable_d & ~stable_q;
    // A new press in the acknowledge cycle survives the clear.
    sticky_d = (sticky_q & ~{WIDTH{rd_ack}}) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign btn_level     = stable_q;
  assign btn_out       = stable_q | sticky_q;
  assign press_pending = |sticky_q;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
module tb_pushbutton_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic       rd_ack;
  logic [3:0] btn_out;
  logic [3:0] btn_level;
  logic       press_pending;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Observed/expected packed as {btn_out, btn_level, press_pending}.
  logic [8:0] obs;
  logic [8:0] exp_v;
  assign obs = {btn_out, btn_level, press_pending};

  pushbutton_conditioner #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .rd_ack       (rd_ack),
    .btn_out      (btn_out),
    .btn_level    (btn_level),
    .press_pending(press_pending)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    btn_raw = 4'hF;
    rd_ack  = 1'b0;
    repeat (3) tick();
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
    reset = 1'b1;                 // next edge is edge 0
    repeat (5) tick();            // edges 0..4
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL reset_rel_e4: got %h want %h", obs, exp_v); end
    tick();                       // edge 5
    exp_v = {4'hF, 4'hF, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL reset_rel_e5: got %h want %h", obs, exp_v); end
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    exp_v = {4'hF, 4'hF, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL reset_ack_held: got %h want %h", obs, exp_v); end
    btn_raw = 4'h0;
    repeat (5) tick();
    exp_v = {4'hF, 4'hF, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL reset_release_e4: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL reset_release_e5: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_clean_press();
    btn_raw = 4'h1;
    repeat (5) tick();
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL clean_e4: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {4'h1, 4'h1, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL clean_e5: got %h want %h", obs, exp_v); end
    btn_raw = 4'h0;
    repeat (6) tick();
    exp_v = {4'h1, 4'h0, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL clean_released: got %h want %h", obs, exp_v); end
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL clean_ack: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_glitch();
    btn_raw = 4'h4;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_v = {4'h0, 4'h0, 1'b0};
      vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL glitch_hi%0d: got %h want %h", k, obs, exp_v); end
    end
    btn_raw = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_v = {4'h0, 4'h0, 1'b0};
      vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL glitch_lo%0d: got %h want %h", k, obs, exp_v); end
    end
  endtask

  task automatic test_exact_pulse();
    btn_raw = 4'h4;
    repeat (4) tick();            // edges 0..3
    btn_raw = 4'h0;
    tick();                       // edge 4
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL exact_e4: got %h want %h", obs, exp_v); end
    tick();                       // edge 5
    exp_v = {4'h4, 4'h4, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL exact_e5: got %h want %h", obs, exp_v); end
    repeat (6) tick();
    exp_v = {4'h4, 4'h0, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL exact_latched: got %h want %h", obs, exp_v); end
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL exact_ack: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_latched_short();
    btn_raw = 4'h2;
    repeat (6) tick();            // edges 0..5
    exp_v = {4'h2, 4'h2, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL short_accept: got %h want %h", obs, exp_v); end
    tick();                       // edge 6, 7th cycle high
    btn_raw = 4'h0;
    repeat (5) tick();            // edges 7..11
    exp_v = {4'h2, 4'h2, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL short_rel_e11: got %h want %h", obs, exp_v); end
    tick();                       // edge 12
    exp_v = {4'h2, 4'h0, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL short_latched: got %h want %h", obs, exp_v); end
    repeat (3) tick();
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL short_persist: got %h want %h", obs, exp_v); end
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL short_ack: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_set_clear_same_edge();
    btn_raw = 4'h8;
    repeat (5) tick();            // edges 0..4
    rd_ack = 1'b1;
    tick();                       // edge 5: accept and ack together
    exp_v = {4'h8, 4'h8, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL setclr_same: got %h want %h", obs, exp_v); end
    tick();                       // edge 6: ack with button held
    rd_ack = 1'b0;
    exp_v = {4'h8, 4'h8, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL setclr_next: got %h want %h", obs, exp_v); end
    btn_raw = 4'h0;
    repeat (6) tick();
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL setclr_release: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_bounce();
    int unsigned bseq [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    for (int k = 0; k < 9; k++) begin
      btn_raw = {3'b000, bseq[k] != 0};
      tick();                     // edge k
      exp_v = {4'h0, 4'h0, 1'b0};
      vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL bounce_e%0d: got %h want %h", k, obs, exp_v); end
    end
    tick();                       // edge 9
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL bounce_e9: got %h want %h", obs, exp_v); end
    tick();                       // edge 10
    exp_v = {4'h1, 4'h1, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL bounce_e10: got %h want %h", obs, exp_v); end
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_v = {4'h1, 4'h1, 1'b0};
      vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL bounce_once%0d: got %h want %h", k, obs, exp_v); end
      tick();
    end
    btn_raw = 4'h0;
    repeat (6) tick();
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL bounce_release: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_independence();
    btn_raw = 4'hB;               // bit 3 only a 2-cycle glitch
    repeat (2) tick();
    btn_raw = 4'h3;
    repeat (3) tick();            // edges 2..4
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL indep_e4: got %h want %h", obs, exp_v); end
    tick();                       // edge 5
    exp_v = {4'h3, 4'h3, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL indep_e5: got %h want %h", obs, exp_v); end
    repeat (4) tick();
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL indep_hold: got %h want %h", obs, exp_v); end
    btn_raw = 4'h2;
    repeat (5) tick();
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL indep_rel_e4: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {4'h3, 4'h2, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL indep_rel_e5: got %h want %h", obs, exp_v); end
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    exp_v = {4'h2, 4'h2, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL indep_ack: got %h want %h", obs, exp_v); end
    btn_raw = 4'h0;
    repeat (6) tick();
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL indep_release: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_reset_midcount();
    btn_raw = 4'h1;
    repeat (6) tick();
    exp_v = {4'h1, 4'h1, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL midrst_accept: got %h want %h", obs, exp_v); end
    btn_raw = 4'h0;
    repeat (3) tick();
    reset = 1'b0;                 // asynchronous: no clock edge before the check
    #1;
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL midrst_async: got %h want %h", obs, exp_v); end
    tick();
    reset = 1'b1;
    repeat (8) tick();
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL midrst_idle: got %h want %h", obs, exp_v); end
    btn_raw = 4'h1;
    repeat (4) tick();            // partial count, then reset
    reset = 1'b0;
    tick();
    reset = 1'b1;                 // held press counts from scratch
    repeat (5) tick();
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL midrst_restart_e4: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {4'h1, 4'h1, 1'b1};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL midrst_restart_e5: got %h want %h", obs, exp_v); end
    btn_raw = 4'h0;
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    repeat (6) tick();
    exp_v = {4'h0, 4'h0, 1'b0};
    vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL midrst_cleanup: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    reset   = 1'b0;
    btn_raw = 4'h0;
    rd_ack  = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_exact_pulse();
    test_latched_short();
    test_set_clear_same_edge();
    test_bounce();
    test_independence();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pushbutton_conditioner.md
# pushbutton_conditioner

Input conditioning stage directly upstream of the Nibbler processor's `pushbuttons` port, which the IN instruction samples onto the data bus. It synchronizes each raw, asynchronous button line into the processor clock domain and debounces it with a per-bit counter. It also latches every debounced press until software acknowledges it, so a short press cannot fall between two IN instructions. The block is 4 bits wide by default and drives `pushbuttons` combinationally from registered state.

## Interface
Parameters:
- `WIDTH`, 4, number of button lines; must equal the processor input width.
- `DEBOUNCE_CYCLES`, 16, consecutive cycles a synchronized level must differ from the accepted level before it is accepted; legal range ≥ 2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  input  1  processor clock.
  - `reset`  input  1  asynchronous, active-low reset.
- `btn_raw`  input  WIDTH  raw button lines, asynchronous to `clk`, 1 = pressed.
- `rd_ack`  input  1  one-cycle pulse marking that the processor has consumed `btn_out`; driven from oeIN qualified by execute phase.
- `btn_out`  output  WIDTH  value presented to processor `pushbuttons`, equal to `btn_level | sticky`.
- `btn_level`  output  WIDTH  debounced current level of each button.
- `press_pending`  output  1  OR-reduction of the sticky register.

## Operation
- Synchronizer:
  - Two flops per bit, `s1 <= btn_raw`, `s2 <= s1`.
  - `s2` is the only signal the rest of the block reads.
- Debounce, per bit, independent:
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - If `s2 == stable`, the counter clears to 0.
  - If `s2 != stable` and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If `s2 != stable` and counter == DEBOUNCE_CYCLES-1, then `stable <= s2` and the counter clears to 0.
  - A single cycle of agreement anywhere in the run restarts the count; there is no partial credit.
- Press latch, per bit:
  - `rise = next_stable & ~stable`, evaluated on the edge where `stable` goes 0→1.
  - `sticky <= (sticky & ~{WIDTH{rd_ack}}) | rise`.
  - Set wins over clear when `rise` and `rd_ack` occur in the same cycle.
  - Release (1→0) never sets or clears `sticky`.
- Outputs:
  - `btn_level = stable`.
  - `btn_out = stable | sticky`.
  - `press_pending = |sticky`.
  - All three are combinational from registers only; there is no path from `btn_raw` or `rd_ack` to any output.
- Reset (low, asynchronous):
  - `s1`, `s2`, `stable`, the counters and `sticky` all clear to 0.
  - `btn_out`, `btn_level` and `press_pending` read 0 while `reset` is low.
  - A press held through reset deassertion is accepted as a new press after the normal debounce latency, and sets `sticky`.
  - Reset asserted mid-count discards the partial count.

## Timing
- Definitions:
  - Edge 0 is the first rising edge that samples a new `btn_raw` value.
  - D is DEBOUNCE_CYCLES.
  - `s2` holds the new value after edge 1.
- Press latency:
  - The counter increments on edges 2..D and reaches D-1 after edge D.
  - `stable` updates on edge D+1, so `btn_level` and `btn_out` change after edge D+1 (D+2 edges total).
  - `sticky` sets on the same edge as `stable`.
- Glitch rejection:
  - A pulse that appears on `s2` for fewer than D consecutive cycles produces no change on any output.
  - A pulse of exactly D cycles is accepted.
- `rd_ack` timing:
  - Clearing takes effect on the edge that samples `rd_ack`=1.
  - `btn_out` then falls the same cycle unless the button is still held (`stable`=1).
- Release latency equals press latency, D+2 edges.
- Bit independence: each bit's counter and sticky register are independent, and simultaneous events on different bits do not interact.

## Test plan
Each scenario below uses D=4.
- Reset: hold `reset`=0 with `btn_raw`=4'hF → all outputs 0; release `reset` with the buttons held → `btn_level`=4'hF and `press_pending`=1 after edge 5 following release.
- Clean press: `btn_raw[0]` 0→1 sampled at edge 0 and held → `btn_level`=4'h1 and `btn_out`=4'h1 after edge 5, not after edge 4.
- Glitch: `btn_raw[2]` high for 3 cycles, then low → `btn_level` and `btn_out` stay 4'h0 throughout, and the counter returns to 0.
- Latched short press: `btn_raw[1]` high for 7 cycles, then released; no `rd_ack` → `btn_out`=4'h2 persists after `btn_level` returns to 0; a single `rd_ack` pulse → `btn_out`=4'h0 on the next edge and `press_pending`=0.
- Simultaneous set and clear: `rd_ack` pulsed on the exact edge where bit 3 is accepted → `sticky[3]`=1 and `btn_out[3]`=1 afterwards; `rd_ack` on the following cycle with the button still held → `sticky` clears while `btn_out[3]` stays 1 from the level.
- Bounce then settle: `btn_raw[0]` toggles 1,0,1,1,0,1,1,1,1 → acceptance happens only after the final run of 4 consecutive 1s at `s2`, and exactly one `sticky` set occurs.
